// File: rtl/vote_logger.sv
// Vote capture front end: button sync/debounce, one-vote-per-press FSM, saturating tallies.
// Define VOTE_TOTAL_EN to add the total_votes output (running sum of all tallies).
module vote_logger #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LOCKOUT_CYCLES  = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode,
   input  logic       button1_raw,
   input  logic       button2_raw,
   input  logic       button3_raw,
   input  logic       button4_raw,
   output logic       valid_vote_casted,
   output logic       invalid_vote,
   output logic [7:0] candidate1_vote,
   output logic [7:0] candidate2_vote,
   output logic [7:0] candidate3_vote,
   output logic [7:0] candidate4_vote,
   output logic       candidate1_button_press,
   output logic       candidate2_button_press,
   output logic       candidate3_button_press,
   output logic       candidate4_button_press
`ifdef VOTE_TOTAL_EN
   ,
   output logic [9:0] total_votes
`endif
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned LkW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LkW-1:0] LkLast = LkW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLockout,
      StWaitRelease
   } state_e;

   logic [3:0]     raw;
   logic [3:0]     meta_q;
   logic [3:0]     sync_q;
   logic [3:0]     db_q;
   logic [3:0]     db_prev_q;
   logic [DbW-1:0] db_cnt_q [4];

   state_e         state_q, state_d;
   logic [LkW-1:0] lock_cnt_q, lock_cnt_d;
   logic           press_event;
   logic           single_press;
   logic           accept;
   logic           reject;
   logic [1:0]     sel_idx;
   logic           sel_saturated;

   logic [7:0]     tally_q [4];
   logic           valid_q;
   logic           invalid_q;

   assign raw = {button4_raw, button3_raw, button2_raw, button1_raw};

   // Two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clock) begin
      if (!reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
      end
   end

   // The debounced level only moves once the synced level has disagreed for DEBOUNCE_CYCLES edges.
   always_ff @(posedge clock) begin
      if (!reset) begin
         db_q      <= '0;
         db_prev_q <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         db_prev_q <= db_q;
         for (int i = 0; i < 4; i++) begin
            if (sync_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbLast) begin
               db_q[i]     <= sync_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press_event  = |(db_q & ~db_prev_q);
   assign single_press = ((db_q & (db_q - 4'd1)) == 4'd0);

   always_comb begin
      sel_idx = 2'd0;
      unique case (db_q)
         4'b0001: sel_idx = 2'd0;
         4'b0010: sel_idx = 2'd1;
         4'b0100: sel_idx = 2'd2;
         4'b1000: sel_idx = 2'd3;
         default: sel_idx = 2'd0;
      endcase
   end

   assign sel_saturated = (tally_q[sel_idx] == 8'hFF);

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state_q)
         StIdle: begin
            if (press_event && !mode) begin
               if (single_press) begin
                  accept     = 1'b1;
                  lock_cnt_d = '0;
                  state_d    = StLockout;
               end else begin
                  reject  = 1'b1;
                  state_d = StWaitRelease;
               end
            end
         end
         StLockout: begin
            if (lock_cnt_q == LkLast) begin
               state_d = StWaitRelease;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         StWaitRelease: begin
            if (db_q == 4'd0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= StIdle;
         lock_cnt_q <= '0;
         valid_q    <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         valid_q    <= accept;
         invalid_q  <= reject;
      end
   end

   // A saturated candidate still gets its strobe; only the count is held at 255.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            tally_q[i] <= '0;
         end
      end else if (accept && !sel_saturated) begin
         tally_q[sel_idx] <= tally_q[sel_idx] + 8'd1;
      end
   end

`ifdef VOTE_TOTAL_EN
   logic [9:0] total_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         total_q <= '0;
      end else if (accept && !sel_saturated) begin
         total_q <= total_q + 10'd1;
      end
   end

   assign total_votes = total_q;

   a_total_is_sum: assert property (@(posedge clock) disable iff (!reset)
      total_q == ({2'b00, tally_q[0]} + {2'b00, tally_q[1]} + {2'b00, tally_q[2]} +
                  {2'b00, tally_q[3]}));
`endif

   a_no_back_to_back_pulse: assert property (@(posedge clock) disable iff (!reset)
      !((valid_q || invalid_q) && $past(valid_q || invalid_q)));

   assign valid_vote_casted       = valid_q;
   assign invalid_vote            = invalid_q;
   assign candidate1_vote         = tally_q[0];
   assign candidate2_vote         = tally_q[1];
   assign candidate3_vote         = tally_q[2];
   assign candidate4_vote         = tally_q[3];
   assign candidate1_button_press = db_q[0];
   assign candidate2_button_press = db_q[1];
   assign candidate3_button_press = db_q[2];
   assign candidate4_button_press = db_q[3];

endmodule
